if_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage RV64I pipeline, sitting in front of the decode stage.
- Owns the architectural fetch PC and drives the 64-bit instruction SRAM request, using a request/grant handshake.
- Supplies pc/pc_valid to decode, which selects the 32-bit half of the returned word by pc[2].
- Handles branch redirects, including redirects that arrive while IF is stalled, and requests a stall when SRAM does not grant.

---
 rtl/if_fetch_pkg.sv | 33 +++
 rtl/if_fetch_redirect_buf.sv | 68 ++++++
 rtl/if_fetch.sv | 113 +++++++++++
 tb/tb_if_fetch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/step defaults,
// the fetch FSM encoding, next-PC source tags and stall-vector bit indices.
package if_fetch_pkg;

    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [63:0] PC_STEP_DEF  = 64'd4;

    // Bit positions inside the pipeline stall vector
    localparam int unsigned STALL_IF = 0;
    localparam int unsigned STALL_ID = 1;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    // Which rule produced next_pc this cycle
    typedef enum logic [2:0] {
        NPC_BOOT   = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_PARK   = 3'd2,
        NPC_PEND   = 3'd3,
        NPC_SEQ    = 3'd4,
        NPC_HOLD   = 3'd5
    } npc_sel_e;

    // SRAM returns 64-bit words; decode picks the half by pc[2]
    function automatic logic [63:0] dw_align(input logic [63:0] addr);
        return {addr[63:3], 3'b000};
    endfunction

endpackage

// File: rtl/if_fetch_redirect_buf.sv
// if_redirect_buf: parks a redirect that arrives while IF is stalled and
// resolves the next-PC priority (branch > parked redirect > sequential > hold).
module if_redirect_buf
    import if_fetch_pkg::*;
#(
    parameter logic [63:0] PC_STEP = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        booting,
    input  logic        stall_if,
    input  logic        br_e,
    input  logic [63:0] br_addr,
    input  logic        fetch_acc,
    input  logic [63:0] cur_pc,
    output logic [63:0] next_pc,
    output npc_sel_e    npc_sel,
    output logic        pend_v
);

    logic        pend_v_q,    pend_v_d;
    logic [63:0] pend_addr_q, pend_addr_d;

    assign pend_v = pend_v_q;

    // Next-PC priority mux and pending-redirect bookkeeping
    always_comb begin
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        next_pc     = cur_pc;
        npc_sel     = NPC_HOLD;
        if (booting) begin
            // A redirect during the boot bubble is honoured directly
            npc_sel = NPC_BOOT;
            if (br_e) begin
                next_pc = br_addr;
            end
        end else if (br_e && !stall_if) begin
            next_pc  = br_addr;
            pend_v_d = 1'b0;
            npc_sel  = NPC_BRANCH;
        end else if (br_e) begin
            // Newest redirect wins: overwrite any earlier parked target
            pend_v_d    = 1'b1;
            pend_addr_d = br_addr;
            npc_sel     = NPC_PARK;
        end else if (pend_v_q && !stall_if) begin
            next_pc  = pend_addr_q;
            pend_v_d = 1'b0;
            npc_sel  = NPC_PEND;
        end else if (fetch_acc) begin
            next_pc = cur_pc + PC_STEP;
            npc_sel = NPC_SEQ;
        end
    end

    // Pending-redirect registers; reset discards any parked redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: IF stage of the RV64I pipeline. Owns the fetch PC, drives the
// instruction SRAM request/grant handshake and hands pc/pc_valid to decode.
// Optional build macro IF_MISALIGN_CHK_EN adds the fetch_misalign output and
// suppresses requests while the PC is not 4-byte aligned.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF,
    parameter logic [63:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  stall,
    input  logic        br_e,
    input  logic [63:0] br_addr,
    output logic        stallreq_if,
    output logic        pc_valid,
    output logic [63:0] pc,
    output logic        inst_sram_req,
    input  logic        inst_sram_gnt,
    output logic [63:0] inst_sram_addr,
`ifdef IF_MISALIGN_CHK_EN
    output logic        fetch_misalign,
`endif
    output logic        inst_sram_we
);

    fetch_state_e state_q,    state_d;
    logic [63:0]  pc_q,       pc_d;
    logic         pc_valid_q, pc_valid_d;
    logic         misalign_q, misalign_d;

    logic         stall_if;
    logic         fetch_acc;
    logic         booting;
    logic [63:0]  next_pc;
    npc_sel_e     npc_sel;
    logic         pend_v;
    logic         unused_stall;

    assign stall_if     = stall[STALL_IF];
    assign unused_stall = &{1'b0, stall[5:1]};
    assign booting      = (state_q == BOOT);

    // Request and stall generation toward SRAM and the hazard unit
    always_comb begin
        inst_sram_req = pc_valid_q & ~booting & ~misalign_q;
        stallreq_if   = inst_sram_req & ~inst_sram_gnt;
        fetch_acc     = inst_sram_req & inst_sram_gnt & ~stall_if;
    end

    assign inst_sram_addr = dw_align(pc_q);
    assign inst_sram_we   = 1'b0;
    assign pc             = pc_q;
    assign pc_valid       = pc_valid_q;
`ifdef IF_MISALIGN_CHK_EN
    assign fetch_misalign = misalign_q;
`endif

    if_redirect_buf #(
        .PC_STEP (PC_STEP)
    ) u_rbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .booting   (booting),
        .stall_if  (stall_if),
        .br_e      (br_e),
        .br_addr   (br_addr),
        .fetch_acc (fetch_acc),
        .cur_pc    (pc_q),
        .next_pc   (next_pc),
        .npc_sel   (npc_sel),
        .pend_v    (pend_v)
    );

    // Next-state, next-PC and misalign flag for the fetch FSM
    always_comb begin
        pc_d       = next_pc;
        pc_valid_d = 1'b1;
        state_d    = state_q;
        if (booting) begin
            state_d = RUN;
        end else begin
            unique case (npc_sel)
                NPC_PARK: state_d = HOLD;
                NPC_HOLD: state_d = (stall_if || pend_v) ? HOLD : RUN;
                default:  state_d = RUN;
            endcase
        end
`ifdef IF_MISALIGN_CHK_EN
        // Registered alongside pc so it always describes the current pc
        misalign_d = pc_valid_d & (pc_d[1:0] != 2'b00);
`else
        misalign_d = 1'b0;
`endif
    end

    // Fetch FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random
// traffic, all compared against a behavioural fetch model.
module tb_if_fetch;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall;
    logic        br_e;
    logic [63:0] br_addr;
    logic        stallreq_if;
    logic        pc_valid;
    logic [63:0] pc;
    logic        inst_sram_req;
    logic        inst_sram_gnt;
    logic [63:0] inst_sram_addr;
    logic        inst_sram_we;
`ifdef IF_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_pc;
    logic        m_valid;
    logic        m_pend;
    logic [63:0] m_pend_addr;
    logic        m_mis;

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (64'd4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .br_e           (br_e),
        .br_addr        (br_addr),
        .stallreq_if    (stallreq_if),
        .pc_valid       (pc_valid),
        .pc             (pc),
        .inst_sram_req  (inst_sram_req),
        .inst_sram_gnt  (inst_sram_gnt),
        .inst_sram_addr (inst_sram_addr),
`ifdef IF_MISALIGN_CHK_EN
        .fetch_misalign (fetch_misalign),
`endif
        .inst_sram_we   (inst_sram_we)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_req();
        return m_valid && !m_mis;
    endfunction

    // Compare every DUT output with the model's view of the current cycle
    task automatic check_all();
        chk("pc_valid", {63'd0, pc_valid}, {63'd0, m_valid});
        chk("pc", pc, m_pc);
        chk("req", {63'd0, inst_sram_req}, {63'd0, model_req()});
        chk("addr", inst_sram_addr, m_pc & ~64'h7);
        chk("stallreq", {63'd0, stallreq_if}, {63'd0, model_req() && !inst_sram_gnt});
        chk("we", {63'd0, inst_sram_we}, 64'd0);
        chk("pend_v", {63'd0, dut.u_rbuf.pend_v_q}, {63'd0, m_pend});
`ifdef IF_MISALIGN_CHK_EN
        chk("misalign", {63'd0, fetch_misalign}, {63'd0, m_mis});
`endif
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_update();
        logic acc;
        acc = model_req() && inst_sram_gnt && !stall[0];
        if (!rst_n) begin
            m_pc = RESET_PC; m_valid = 1'b0; m_pend = 1'b0; m_pend_addr = '0;
        end else if (!m_valid) begin
            if (br_e) m_pc = br_addr;
            m_valid = 1'b1;
        end else if (br_e && !stall[0]) begin
            m_pc = br_addr; m_pend = 1'b0;
        end else if (br_e) begin
            m_pend = 1'b1; m_pend_addr = br_addr;
        end else if (m_pend && !stall[0]) begin
            m_pc = m_pend_addr; m_pend = 1'b0;
        end else if (acc) begin
            m_pc = m_pc + 64'd4;
        end
`ifdef IF_MISALIGN_CHK_EN
        m_mis = m_valid && (m_pc[1:0] != 2'b00);
`else
        m_mis = 1'b0;
`endif
    endtask

    task automatic tick();
        #1;
        check_all();
        model_update();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall = '0; br_e = 1'b0; br_addr = '0; inst_sram_gnt = 1'b1;
        m_mis = 1'b0;
        model_update();
        @(negedge clk);
        tick();
        tick();

        // Reset release: one boot bubble, then sequential fetch
        rst_n = 1'b1;
        tick();
        #1; chk("tp_first_pc", pc, 64'h8000_0000);
        chk("tp_first_req", {63'd0, inst_sram_req}, 64'd1);
        tick();
        #1; chk("tp_pc_4", pc, 64'h8000_0004);
        chk("tp_addr_4", inst_sram_addr, 64'h8000_0000);
        tick();
        #1; chk("tp_pc_8", pc, 64'h8000_0008);
        chk("tp_addr_8", inst_sram_addr, 64'h8000_0008);
        tick();
        tick();

        // No grant for three cycles at 0x8000_0010
        inst_sram_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("tp_nogrant_stallreq", {63'd0, stallreq_if}, 64'd1);
            chk("tp_nogrant_pc", pc, 64'h8000_0010);
            tick();
        end
        inst_sram_gnt = 1'b1;
        tick();
        #1; chk("tp_after_grant", pc, 64'h8000_0014);

        // Unstalled redirect
        br_e = 1'b1; br_addr = 64'h8000_1000;
        tick();
        br_e = 1'b0;
        #1; chk("tp_br_pc", pc, 64'h8000_1000);
        tick();
        #1; chk("tp_br_seq", pc, 64'h8000_1004);

        // Two redirects during a four-cycle stall; the newest must win
        stall = 6'b000001;
        tick();
        br_e = 1'b1; br_addr = 64'h9000;
        tick();
        br_addr = 64'hA000;
        tick();
        br_e = 1'b0;
        tick();
        #1; chk("tp_stall_hold", pc, 64'h8000_1004);
        stall = '0;
        tick();
        #1; chk("tp_pend_pc", pc, 64'hA000);
        chk("tp_pend_clr", {63'd0, dut.u_rbuf.pend_v_q}, 64'd0);

        // PC wraps modulo 2^64
        br_e = 1'b1; br_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        br_e = 1'b0;
        tick();
        #1; chk("tp_wrap", pc, 64'd0);

        // Reset while a redirect is parked discards it
        stall = 6'b000001; br_e = 1'b1; br_addr = 64'h5000;
        tick();
        br_e = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; stall = '0;
        tick();
        #1; chk("tp_rst_pend_pc", pc, RESET_PC);
        tick();
        #1; chk("tp_rst_pend_seq", pc, RESET_PC + 64'd4);

`ifdef IF_MISALIGN_CHK_EN
        br_e = 1'b1; br_addr = 64'h8000_0002;
        tick();
        br_e = 1'b0;
        #1; chk("tp_mis_flag", {63'd0, fetch_misalign}, 64'd1);
        chk("tp_mis_req", {63'd0, inst_sram_req}, 64'd0);
        tick();
        #1; chk("tp_mis_hold", pc, 64'h8000_0002);
        br_e = 1'b1; br_addr = 64'h8000_0100;
        tick();
        br_e = 1'b0;
        #1; chk("tp_mis_clear", {63'd0, fetch_misalign}, 64'd0);
        chk("tp_mis_req_back", {63'd0, inst_sram_req}, 64'd1);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst_n         = ($urandom % 80) != 0;
            inst_sram_gnt = ($urandom % 4) != 0;
            stall         = 6'($urandom);
            stall[0]      = ($urandom % 4) == 0;
            br_e          = ($urandom % 8) == 0;
            br_addr       = {$urandom, $urandom};
            if (($urandom % 8) != 0) br_addr[1:0] = 2'b00;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
